// File: rtl/accum_avm_host.sv
// Streams IEEE-754 samples into an Avalon-MM accumulator slave: clear, feed N samples, read back the sum.
// Optional waitrequest watchdog enabled by defining ACCM_TIMEOUT_EN.
module accum_avm_host #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             avm_address,
    output logic             avm_write,
    output logic             avm_read,
    output logic [31:0]      avm_writedata,
    input  logic [31:0]      avm_readdata,
    input  logic             avm_waitrequest,
    output logic             busy,
    output logic             result_valid,
    output logic [31:0]      result_data,
    output logic             err
);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, READ, DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] remaining_d;
    logic             avm_write_q;
    logic             avm_read_q;
    logic             avm_address_q;
    logic [31:0]      avm_writedata_q;
    logic             busy_q;
    logic             result_valid_q;
    logic [31:0]      result_data_q;
    logic             accept;
    logic             xferDone;

    // A new sample may only be taken once the previous write has left the bus.
    assign s_ready  = (state_q == FEED) && (!avm_write_q || !avm_waitrequest) && (remaining_q != '0);
    assign accept   = s_valid && s_ready;
    assign xferDone = (avm_write_q || avm_read_q) && !avm_waitrequest;

    always_comb begin
        remaining_d = remaining_q;
        if (remaining_q != '0)
            remaining_d = remaining_q - CNT_W'(1);
    end

`ifdef ACCM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_q;
    logic            stalled;
    logic            timeout;
    logic            err_q;

    assign stalled = (avm_write_q || avm_read_q) && avm_waitrequest;
    assign timeout = stalled && (wd_q == WD_W'(TIMEOUT_CYC - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wd_q <= '0;
        else if (stalled && !timeout)
            wd_q <= wd_q + WD_W'(1);
        else
            wd_q <= '0;
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            avm_write_q     <= 1'b0;
            avm_read_q      <= 1'b0;
            avm_address_q   <= 1'b0;
            avm_writedata_q <= '0;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            result_data_q   <= '0;
`ifdef ACCM_TIMEOUT_EN
            err_q           <= 1'b0;
`endif
        end else begin
            result_valid_q <= 1'b0;
`ifdef ACCM_TIMEOUT_EN
            err_q          <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        remaining_q     <= count;
                        busy_q          <= 1'b1;
                        avm_write_q     <= 1'b1;
                        avm_address_q   <= 1'b1;
                        avm_writedata_q <= '0;
                        state_q         <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (!avm_waitrequest) begin
                        avm_write_q <= 1'b0;
                        if (remaining_q != '0) begin
                            state_q <= FEED;
                        end else begin
                            avm_read_q <= 1'b1;
                            state_q    <= READ;
                        end
                    end
                end
                FEED: begin
                    if (accept) begin
                        avm_write_q     <= 1'b1;
                        avm_address_q   <= 1'b0;
                        avm_writedata_q <= s_data;
                        remaining_q     <= remaining_d;
                    end else if (xferDone) begin
                        avm_write_q <= 1'b0;
                        if (remaining_q == '0) begin
                            avm_read_q    <= 1'b1;
                            avm_address_q <= 1'b1;
                            state_q       <= READ;
                        end
                    end
                end
                READ: begin
                    if (!avm_waitrequest) begin
                        avm_read_q     <= 1'b0;
                        result_data_q  <= avm_readdata;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef ACCM_TIMEOUT_EN
            // Watchdog abort overrides whatever the state logic chose this cycle.
            if (timeout) begin
                avm_write_q <= 1'b0;
                avm_read_q  <= 1'b0;
                busy_q      <= 1'b0;
                err_q       <= 1'b1;
                state_q     <= IDLE;
            end
`endif
        end
    end

    assign avm_write     = avm_write_q;
    assign avm_read      = avm_read_q;
    assign avm_address   = avm_address_q;
    assign avm_writedata = avm_writedata_q;
    assign busy          = busy_q;
    assign result_valid  = result_valid_q;
    assign result_data   = result_data_q;

endmodule

// File: tb/tb_accum_avm_host.sv
// Directed bench for accum_avm_host: stalling Avalon slave model, sample source and bus monitor.
// Watchdog scenario is exercised only when ACCM_TIMEOUT_EN is defined.
module tb_accum_avm_host;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  jobCount = '0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        avm_address;
    logic        avm_write;
    logic        avm_read;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        result_valid;
    logic [31:0] result_data;
    logic        err;

    int          total = 0;
    int          bad = 0;
    int          stallCfg = 0;
    int          stallLeft = 0;
    logic        holdRead = 1'b0;
    logic [31:0] readValue = '0;
    logic [31:0] sampleQ[$];
    logic        hsNext = 1'b0;
    int          hsCount = 0;
    logic [33:0] xferQ[$];
    logic [33:0] expQ[$];
    int          rvCount = 0;
    int          errCount = 0;
    int          stallSeen = 0;
    int          sReadyCount = 0;
    logic        prevStall = 1'b0;
    logic [34:0] prevBus = '0;
    logic        pending;

    accum_avm_host #(.CNT_W(8), .TIMEOUT_CYC(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .count           (jobCount),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .result_valid    (result_valid),
        .result_data     (result_data),
        .err             (err)
    );

    always #5 clk = ~clk;

    assign pending         = avm_write || avm_read;
    assign avm_readdata    = avm_read ? readValue : 32'h0;
    assign avm_waitrequest = (pending && stallLeft != 0) || (holdRead && avm_read);

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Slave stalls every transfer for stallCfg cycles before accepting it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stallLeft <= stallCfg;
        else if (!pending || !avm_waitrequest)
            stallLeft <= stallCfg;
        else if (stallLeft > 0)
            stallLeft <= stallLeft - 1;
    end

    // Sample source: inputs only change on the falling edge.
    always @(negedge clk) begin
        if (hsNext) begin
            void'(sampleQ.pop_front());
            hsCount++;
        end
        s_valid = (sampleQ.size() > 0);
        s_data  = s_valid ? sampleQ[0] : 32'h0;
        hsNext  = s_valid && s_ready && reset_n;
    end

    // Bus monitor: logs completed transfers and checks stall stability.
    always @(negedge clk) begin
        if (reset_n) begin
            if (result_valid) rvCount++;
            if (err) errCount++;
            if (s_ready) sReadyCount++;
            if (pending) checkOutput("rw_excl", 64'(avm_write && avm_read), 64'd0);
            if (prevStall && !err)
                checkOutput("stall_hold", 64'({avm_write, avm_read, avm_address, avm_writedata}), 64'(prevBus));
            prevStall = pending && avm_waitrequest;
            prevBus   = {avm_write, avm_read, avm_address, avm_writedata};
            if (pending && avm_waitrequest) stallSeen++;
            if (pending && !avm_waitrequest)
                xferQ.push_back({avm_read, avm_address, avm_read ? 32'h0 : avm_writedata});
        end else begin
            prevStall = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [7:0] cnt);
        @(negedge clk);
        start    = 1'b1;
        jobCount = cnt;
        @(negedge clk);
        start    = 1'b0;
        jobCount = 8'd0;
        checkOutput("clear_issue", 64'({busy, avm_write, avm_read, avm_address, avm_writedata}), 64'({4'b1101, 32'h0}));
    endtask

    task automatic waitResult(input string tag, input logic [31:0] expData);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (result_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_rv_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            checkOutput({tag, "_result"}, 64'(result_data), 64'(expData));
            @(negedge clk);
            checkOutput({tag, "_rv_pulse"}, 64'({result_valid, busy}), 64'd0);
        end
    endtask

    task automatic checkXfers(input string tag);
        checkOutput({tag, "_xfer_cnt"}, 64'(xferQ.size()), 64'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < xferQ.size(); i++)
            checkOutput($sformatf("%s_xfer%0d", tag, i), 64'(xferQ[i]), 64'(expQ[i]));
    endtask

    task automatic loadJob2();
        sampleQ.push_back(32'h437f0000);
        sampleQ.push_back(32'h43000000);
        readValue = 32'h43bf8000;
        xferQ.delete();
        expQ = '{{2'b01, 32'h0}, {2'b00, 32'h437f0000}, {2'b00, 32'h43000000}, {2'b11, 32'h0}};
    endtask

    initial begin
        int rvBase;
        int hsBase;
        int srBase;
        bit found;

        // Reset state
        #3;
        checkOutput("reset_ctl", 64'({s_ready, avm_write, avm_read, busy, result_valid, err, avm_address}), 64'd0);
        checkOutput("reset_data", 64'({avm_writedata, result_data}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic two-sample job, no stalls
        loadJob2();
        rvBase = rvCount;
        applyStimulus(8'd2);
        waitResult("job2", 32'h43bf8000);
        checkXfers("job2");
        checkOutput("job2_rv_once", 64'(rvCount - rvBase), 64'd1);
        checkOutput("job2_consumed", 64'(sampleQ.size()), 64'd0);

        // Same job with three stall cycles on every transfer
        stallCfg = 3;
        @(negedge clk);
        loadJob2();
        stallSeen = 0;
        applyStimulus(8'd2);
        waitResult("stall", 32'h43bf8000);
        checkXfers("stall");
        checkOutput("stall_cycles", 64'(stallSeen), 64'd12);

        // Zero-count job: clear then straight to read, no handshakes
        stallCfg = 0;
        @(negedge clk);
        sampleQ.push_back(32'h11111111);
        readValue = 32'h12345678;
        xferQ.delete();
        expQ   = '{{2'b01, 32'h0}, {2'b11, 32'h0}};
        hsBase = hsCount;
        srBase = sReadyCount;
        applyStimulus(8'd0);
        waitResult("zero", 32'h12345678);
        checkXfers("zero");
        checkOutput("zero_no_hs", 64'(hsCount - hsBase), 64'd0);
        checkOutput("zero_no_ready", 64'(sReadyCount - srBase), 64'd0);
        sampleQ.delete();

        // Start pulsed mid-job must be ignored
        stallCfg = 1;
        @(negedge clk);
        loadJob2();
        rvBase = rvCount;
        applyStimulus(8'd2);
        @(negedge clk);
        start    = 1'b1;
        jobCount = 8'd7;
        @(negedge clk);
        start    = 1'b0;
        jobCount = 8'd0;
        waitResult("busy_start", 32'h43bf8000);
        checkXfers("busy_start");
        repeat (5) @(negedge clk);
        checkOutput("busy_start_idle", 64'({busy, avm_write, avm_read}), 64'd0);
        checkOutput("busy_start_rv", 64'(rvCount - rvBase), 64'd1);

        // Reset during FEED after one of three samples
        stallCfg = 0;
        sampleQ.push_back(32'h40000000);
        sampleQ.push_back(32'h40400000);
        sampleQ.push_back(32'h40800000);
        hsBase = hsCount;
        applyStimulus(8'd3);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (hsCount - hsBase >= 1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("rst_mid_hs", 64'(found), 64'd1);
        #2;
        reset_n = 1'b0;
        sampleQ.delete();
        hsNext = 1'b0;
        #1;
        checkOutput("rst_mid_ctl", 64'({s_ready, avm_write, avm_read, busy, result_valid, err, avm_address}), 64'd0);
        checkOutput("rst_mid_data", 64'({avm_writedata, result_data}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        xferQ.delete();
        sampleQ.push_back(32'h3f800000);
        readValue = 32'h3f800000;
        expQ = '{{2'b01, 32'h0}, {2'b00, 32'h3f800000}, {2'b11, 32'h0}};
        applyStimulus(8'd1);
        waitResult("post_rst", 32'h3f800000);
        checkXfers("post_rst");

`ifdef ACCM_TIMEOUT_EN
        // Read held stalled until the watchdog fires
        begin
            int readCyc = 0;
            bit errSeen = 1'b0;
            rvBase   = rvCount;
            holdRead = 1'b1;
            applyStimulus(8'd0);
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (err) begin
                    errSeen = 1'b1;
                    break;
                end
                if (avm_read) readCyc++;
            end
            checkOutput("wd_err_seen", 64'(errSeen), 64'd1);
            checkOutput("wd_read_cycles", 64'(readCyc), 64'd4);
            checkOutput("wd_abort_state", 64'({busy, avm_read, avm_write}), 64'd0);
            @(negedge clk);
            checkOutput("wd_err_pulse", 64'(err), 64'd0);
            checkOutput("wd_no_result", 64'(rvCount - rvBase), 64'd0);
            checkOutput("wd_err_count", 64'(errCount), 64'd1);
            holdRead = 1'b0;
        end
`else
        checkOutput("err_never", 64'(errCount), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
